// File: rtl/tlc_pkg.sv
// tlc_pkg: shared state codes and active-low lamp encodings for the traffic-light controller.
package tlc_pkg;
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        A_GRN = 3'd1,
        A_YEL = 3'd2,
        AR1   = 3'd3,
        B_GRN = 3'd4,
        B_YEL = 3'd5,
        AR2   = 3'd6,
        FLASH = 3'd7
    } state_t;

    localparam logic [2:0] LT_RED = 3'b011;
    localparam logic [2:0] LT_YEL = 3'b101;
    localparam logic [2:0] LT_GRN = 3'b110;
    localparam logic [2:0] LT_OFF = 3'b111;

    // {lt1, lt2} steady lamps for a state; FLASH blinking is handled by the controller
    function automatic logic [5:0] lamps_of(input state_t s);
        case (s)
            A_GRN:    return {LT_GRN, LT_RED};
            A_YEL:    return {LT_YEL, LT_RED};
            AR1, AR2: return {LT_RED, LT_RED};
            B_GRN:    return {LT_RED, LT_GRN};
            B_YEL:    return {LT_RED, LT_YEL};
            default:  return {LT_YEL, LT_YEL};
        endcase
    endfunction
endpackage

// File: rtl/tlc_tick_gen.sv
// tlc_tick_gen: one-second prescaler; held at zero while disabled, pulses o_sec_tick on its last count.
module tlc_tick_gen #(
    parameter int CLK_HZ = 100_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_en,
    output logic o_sec_tick
);
    localparam int PW = $clog2(CLK_HZ);
    localparam logic [PW-1:0] LAST = PW'(CLK_HZ - 1);

    logic [PW-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_cnt <= '0;
        else
            r_cnt <= (!i_en || r_cnt == LAST) ? '0 : r_cnt + 1'b1;
    end

    assign o_sec_tick = i_en && (r_cnt == LAST);
endmodule

// File: rtl/tlc_param_ctrl.sv
// tlc_param_ctrl: two-direction traffic-light controller with all-red clearance, pedestrian truncation
// and countdown output; define TLC_NIGHT_FLASH_EN to add the night input and the flashing-yellow mode.
module tlc_param_ctrl
    import tlc_pkg::*;
#(
    parameter int CLK_HZ    = 100_000_000,
    parameter int GREEN_S   = 20,
    parameter int YELLOW_S  = 3,
    parameter int ALLRED_S  = 1,
    parameter int PED_MIN_S = 5,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
`ifdef TLC_NIGHT_FLASH_EN
    input  logic             night,
`endif
    input  logic             ped_req_a,
    input  logic             ped_req_b,
    output logic [2:0]       lt1,
    output logic [2:0]       lt2,
    output logic [CNT_W-1:0] remain,
    output logic [2:0]       phase,
    output logic             sec_tick
);
    localparam logic [CNT_W-1:0] G_LD  = CNT_W'(GREEN_S - 1);
    localparam logic [CNT_W-1:0] Y_LD  = CNT_W'(YELLOW_S - 1);
    localparam logic [CNT_W-1:0] AR_LD = CNT_W'(ALLRED_S > 0 ? ALLRED_S - 1 : 0);
    localparam logic [CNT_W-1:0] P_LD  = CNT_W'(PED_MIN_S - 1);

    state_t           r_state, w_nxt_state;
    logic [CNT_W-1:0] r_remain, w_nxt_remain;
    logic [2:0]       r_lt1, r_lt2, w_nxt_lt1, w_nxt_lt2;
    logic             w_tick, w_night, w_ped, w_flash_tog;

`ifdef TLC_NIGHT_FLASH_EN
    assign w_night = night;
`else
    assign w_night = 1'b0;
`endif

    // with no clearance time the all-red phases are skipped entirely
    function automatic state_t next_phase(input state_t s);
        case (s)
            A_GRN:   return A_YEL;
            A_YEL:   return (ALLRED_S == 0) ? B_GRN : AR1;
            AR1:     return B_GRN;
            B_GRN:   return B_YEL;
            B_YEL:   return (ALLRED_S == 0) ? A_GRN : AR2;
            default: return A_GRN;
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] load_of(input state_t s);
        case (s)
            A_GRN, B_GRN: return G_LD;
            A_YEL, B_YEL: return Y_LD;
            AR1, AR2:     return AR_LD;
            default:      return '0;
        endcase
    endfunction

    tlc_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
        .clk       (clk),
        .reset     (reset),
        .i_en      (r_state != IDLE),
        .o_sec_tick(w_tick)
    );

    assign w_ped = (r_state == A_GRN && ped_req_a) || (r_state == B_GRN && ped_req_b);

    always_comb begin
        w_nxt_state  = r_state;
        w_nxt_remain = r_remain;
        w_flash_tog  = 1'b0;
        if (r_state == IDLE) begin
            w_nxt_state  = A_GRN;
            w_nxt_remain = G_LD;
        end else if (r_state == FLASH) begin
            if (w_tick && w_night)
                w_flash_tog = 1'b1;
            else if (w_tick) begin
                w_nxt_state  = (ALLRED_S == 0) ? A_GRN : AR2;
                w_nxt_remain = (ALLRED_S == 0) ? G_LD : AR_LD;
            end
        end else if (w_tick && w_night) begin
            w_nxt_state  = FLASH;
            w_nxt_remain = '0;
        end else if (w_ped && r_remain > P_LD) begin
            w_nxt_remain = P_LD;
        end else if (w_tick) begin
            w_nxt_state  = (r_remain == '0) ? next_phase(r_state) : r_state;
            w_nxt_remain = (r_remain == '0) ? load_of(next_phase(r_state)) : r_remain - 1'b1;
        end
        {w_nxt_lt1, w_nxt_lt2} = lamps_of(w_nxt_state);
        if (r_state == FLASH && w_nxt_state == FLASH) begin
            w_nxt_lt1 = w_flash_tog ? ((r_lt1 == LT_YEL) ? LT_OFF : LT_YEL) : r_lt1;
            w_nxt_lt2 = w_nxt_lt1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_remain <= '0;
            r_lt1    <= LT_YEL;
            r_lt2    <= LT_YEL;
        end else begin
            r_state  <= w_nxt_state;
            r_remain <= w_nxt_remain;
            r_lt1    <= w_nxt_lt1;
            r_lt2    <= w_nxt_lt2;
        end
    end

    assign lt1      = r_lt1;
    assign lt2      = r_lt2;
    assign remain   = r_remain;
    assign phase    = r_state;
    assign sec_tick = w_tick;
endmodule

// File: tb/tb_tlc_param_ctrl.sv
// tb_tlc_param_ctrl: directed checks of tlc_param_ctrl with a 10-cycle second; a second instance
// built with ALLRED_S=0 checks the skipped clearance phases.
module tb_tlc_param_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       pa = 1'b0, pb = 1'b0, night = 1'b0;
    logic [2:0] lt1a, lt2a, ph_a, lt1b, lt2b, ph_b;
    logic [7:0] rem_a, rem_b;
    logic       tk_a, tk_b;
    int         asserts = 0;
    int         fails = 0;

    always #5 clk = ~clk;

    tlc_param_ctrl #(.CLK_HZ(10), .GREEN_S(4), .YELLOW_S(2), .ALLRED_S(1), .PED_MIN_S(2), .CNT_W(8)) dut_a (
        .clk(clk), .reset(reset),
`ifdef TLC_NIGHT_FLASH_EN
        .night(night),
`endif
        .ped_req_a(pa), .ped_req_b(pb), .lt1(lt1a), .lt2(lt2a), .remain(rem_a), .phase(ph_a), .sec_tick(tk_a));

    tlc_param_ctrl #(.CLK_HZ(10), .GREEN_S(4), .YELLOW_S(2), .ALLRED_S(0), .PED_MIN_S(2), .CNT_W(8)) dut_b (
        .clk(clk), .reset(reset),
`ifdef TLC_NIGHT_FLASH_EN
        .night(night),
`endif
        .ped_req_a(pa), .ped_req_b(pb), .lt1(lt1b), .lt2(lt2b), .remain(rem_b), .phase(ph_b), .sec_tick(tk_b));

    // counts cycles spent in the current phase (starting from its first sampled cycle) and ticks seen
    task automatic measure(input bit sel, output int n, output logic [2:0] nxt, output int ticks);
        logic [2:0] p0;
        p0 = sel ? ph_b : ph_a;
        nxt = p0;
        n = 1;
        ticks = int'(sel ? tk_b : tk_a);
        for (int i = 0; i < 500; i++) begin
            @(posedge clk); #1;
            if ((sel ? ph_b : ph_a) != p0) begin
                nxt = sel ? ph_b : ph_a;
                return;
            end
            n++;
            ticks += int'(sel ? tk_b : tk_a);
        end
        n = -1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        asserts++; if (lt1a !== 3'b101) begin fails++; $display("FAIL reset_lt1 got %b want 101", lt1a); end
        asserts++; if (lt2a !== 3'b101) begin fails++; $display("FAIL reset_lt2 got %b want 101", lt2a); end
        asserts++; if (ph_a !== 3'd0) begin fails++; $display("FAIL reset_phase got %0d want 0", ph_a); end
        asserts++; if (rem_a !== 8'd0) begin fails++; $display("FAIL reset_remain got %0d want 0", rem_a); end
        asserts++; if (tk_a !== 1'b0) begin fails++; $display("FAIL reset_tick got %b want 0", tk_a); end
        reset = 1'b1;
        @(posedge clk); #1;
        asserts++; if (lt1a !== 3'b110) begin fails++; $display("FAIL release_lt1 got %b want 110", lt1a); end
        asserts++; if (lt2a !== 3'b011) begin fails++; $display("FAIL release_lt2 got %b want 011", lt2a); end
        asserts++; if (ph_a !== 3'd1) begin fails++; $display("FAIL release_phase got %0d want 1", ph_a); end
        asserts++; if (rem_a !== 8'd3) begin fails++; $display("FAIL release_remain got %0d want 3", rem_a); end
    endtask

    task automatic test_free_run();
        int         ph[6]  = '{1, 2, 3, 4, 5, 6};
        int         dur[6] = '{40, 20, 10, 40, 20, 10};
        int         nx[6]  = '{2, 3, 4, 5, 6, 1};
        int         rm[6]  = '{3, 1, 0, 3, 1, 0};
        logic [5:0] lm[6]  = '{6'b110011, 6'b101011, 6'b011011, 6'b011110, 6'b011101, 6'b011011};
        int         n, t, total;
        logic [2:0] nxt;
        total = 0;
        for (int i = 0; i < 6; i++) begin
            asserts++; if (ph_a !== 3'(ph[i])) begin fails++; $display("FAIL run_phase[%0d] got %0d want %0d", i, ph_a, ph[i]); end
            asserts++; if (rem_a !== 8'(rm[i])) begin fails++; $display("FAIL run_entry_remain[%0d] got %0d want %0d", i, rem_a, rm[i]); end
            asserts++; if ({lt1a, lt2a} !== lm[i]) begin fails++; $display("FAIL run_lamps[%0d] got %b want %b", i, {lt1a, lt2a}, lm[i]); end
            measure(1'b0, n, nxt, t);
            total += n;
            asserts++; if (n != dur[i]) begin fails++; $display("FAIL run_duration[%0d] got %0d want %0d", i, n, dur[i]); end
            asserts++; if (nxt !== 3'(nx[i])) begin fails++; $display("FAIL run_next[%0d] got %0d want %0d", i, nxt, nx[i]); end
            asserts++; if (t != dur[i] / 10) begin fails++; $display("FAIL run_ticks[%0d] got %0d want %0d", i, t, dur[i] / 10); end
        end
        asserts++; if (total != 140) begin fails++; $display("FAIL run_period got %0d want 140", total); end
    endtask

    task automatic test_ped();
        asserts++; if (ph_a !== 3'd1 || rem_a !== 8'd3) begin fails++; $display("FAIL ped_start got ph %0d rem %0d want ph 1 rem 3", ph_a, rem_a); end
        pa = 1'b1; @(posedge clk); #1; pa = 1'b0;
        asserts++; if (rem_a !== 8'd1) begin fails++; $display("FAIL ped_clamp got %0d want 1", rem_a); end
        pa = 1'b1; @(posedge clk); #1; pa = 1'b0;
        asserts++; if (rem_a !== 8'd1) begin fails++; $display("FAIL ped_low_ignored got %0d want 1", rem_a); end
        repeat (17) @(posedge clk);
        #1;
        asserts++; if (ph_a !== 3'd1 || rem_a !== 8'd0) begin fails++; $display("FAIL ped_last_cycle got ph %0d rem %0d want ph 1 rem 0", ph_a, rem_a); end
        @(posedge clk); #1;
        asserts++; if (ph_a !== 3'd2 || rem_a !== 8'd1) begin fails++; $display("FAIL ped_to_yellow got ph %0d rem %0d want ph 2 rem 1", ph_a, rem_a); end
        for (int i = 0; i < 40 && ph_a != 3'd4; i++) begin @(posedge clk); #1; end
        asserts++; if (ph_a !== 3'd4 || rem_a !== 8'd3) begin fails++; $display("FAIL ped_bgrn_entry got ph %0d rem %0d want ph 4 rem 3", ph_a, rem_a); end
        pa = 1'b1; @(posedge clk); #1; pa = 1'b0;
        asserts++; if (ph_a !== 3'd4 || rem_a !== 8'd3) begin fails++; $display("FAIL ped_a_in_bgrn got ph %0d rem %0d want ph 4 rem 3", ph_a, rem_a); end
        for (int i = 0; i < 20 && tk_a != 1'b1; i++) begin @(posedge clk); #1; end
        asserts++; if (tk_a !== 1'b1 || rem_a !== 8'd3) begin fails++; $display("FAIL ped_wait_tick got tick %b rem %0d want tick 1 rem 3", tk_a, rem_a); end
        pb = 1'b1; @(posedge clk); #1; pb = 1'b0;
        asserts++; if (rem_a !== 8'd1) begin fails++; $display("FAIL ped_b_with_tick got %0d want 1", rem_a); end
    endtask

    task automatic test_reset_mid();
        int         n, t;
        logic [2:0] nxt;
        for (int i = 0; i < 100 && ph_a != 3'd5; i++) begin @(posedge clk); #1; end
        asserts++; if (ph_a !== 3'd5) begin fails++; $display("FAIL mid_reach_byel got %0d want 5", ph_a); end
        #2 reset = 1'b0;
        #1;
        asserts++; if (lt1a !== 3'b101 || lt2a !== 3'b101) begin fails++; $display("FAIL mid_reset_lamps got %b/%b want 101/101", lt1a, lt2a); end
        asserts++; if (ph_a !== 3'd0 || rem_a !== 8'd0) begin fails++; $display("FAIL mid_reset_state got ph %0d rem %0d want ph 0 rem 0", ph_a, rem_a); end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        asserts++; if (ph_a !== 3'd1 || rem_a !== 8'd3) begin fails++; $display("FAIL mid_release got ph %0d rem %0d want ph 1 rem 3", ph_a, rem_a); end
        measure(1'b0, n, nxt, t);
        asserts++; if (n != 40 || nxt !== 3'd2) begin fails++; $display("FAIL mid_full_green got %0d cycles next %0d want 40 next 2", n, nxt); end
    endtask

    task automatic test_allred0();
        int         ph[4]  = '{1, 2, 4, 5};
        int         dur[4] = '{40, 20, 40, 20};
        int         nx[4]  = '{2, 4, 5, 1};
        int         rm[4]  = '{3, 1, 3, 1};
        int         n, t, total;
        logic [2:0] nxt;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        total = 0;
        for (int i = 0; i < 4; i++) begin
            asserts++; if (ph_b !== 3'(ph[i]) || rem_b !== 8'(rm[i])) begin fails++; $display("FAIL ar0_entry[%0d] got ph %0d rem %0d want ph %0d rem %0d", i, ph_b, rem_b, ph[i], rm[i]); end
            measure(1'b1, n, nxt, t);
            total += n;
            asserts++; if (n != dur[i] || nxt !== 3'(nx[i])) begin fails++; $display("FAIL ar0_phase[%0d] got %0d cycles next %0d want %0d next %0d", i, n, nxt, dur[i], nx[i]); end
        end
        asserts++; if (total != 120) begin fails++; $display("FAIL ar0_period got %0d want 120", total); end
    endtask

`ifdef TLC_NIGHT_FLASH_EN
    task automatic test_night();
        int         n, t;
        logic [2:0] nxt;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        for (int i = 0; i < 100 && ph_a != 3'd4; i++) begin @(posedge clk); #1; end
        night = 1'b1;
        for (int i = 0; i < 20 && ph_a != 3'd7; i++) begin @(posedge clk); #1; end
        asserts++; if (ph_a !== 3'd7 || rem_a !== 8'd0) begin fails++; $display("FAIL night_enter got ph %0d rem %0d want ph 7 rem 0", ph_a, rem_a); end
        asserts++; if (lt1a !== 3'b101 || lt2a !== 3'b101) begin fails++; $display("FAIL night_yel got %b/%b want 101/101", lt1a, lt2a); end
        repeat (10) @(posedge clk);
        #1;
        asserts++; if (lt1a !== 3'b111 || lt2a !== 3'b111) begin fails++; $display("FAIL night_off got %b/%b want 111/111", lt1a, lt2a); end
        repeat (10) @(posedge clk);
        #1;
        asserts++; if (lt1a !== 3'b101 || lt2a !== 3'b101) begin fails++; $display("FAIL night_yel2 got %b/%b want 101/101", lt1a, lt2a); end
        night = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        asserts++; if (ph_a !== 3'd6 || rem_a !== 8'd0) begin fails++; $display("FAIL night_exit got ph %0d rem %0d want ph 6 rem 0", ph_a, rem_a); end
        measure(1'b0, n, nxt, t);
        asserts++; if (n != 10 || nxt !== 3'd1 || rem_a !== 8'd3) begin fails++; $display("FAIL night_ar2 got %0d cycles next %0d rem %0d want 10 next 1 rem 3", n, nxt, rem_a); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_free_run();
        test_ped();
        test_reset_mid();
        test_allred0();
`ifdef TLC_NIGHT_FLASH_EN
        test_night();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end
endmodule
